// File: rtl/ipsxe_floating_point_op_channel_v1_1.sv
// Buffered AXI4-Stream operation channel: decodes operation beats into 3-bit codes,
// flags illegal dynamic codes and queues them in a DEPTH-entry FIFO for the core.
module ipsxe_floating_point_op_channel_v1_1 #(
  parameter int OP_SEL        = 0,
  parameter int OP_PLUS_MINUS = 0,
  parameter int OP_COMPARE    = 0,
  parameter int TDATA_W       = 8,
  parameter int DEPTH         = 4,
  parameter int DROP_ILLEGAL  = 0
) (
  input  logic                       i_aclk,
  input  logic                       i_aresetn,
  input  logic                       i_axi4s_operation_tvalid,
  output logic                       o_axi4s_operation_tready,
  input  logic [TDATA_W-1:0]         i_axi4s_operation_tdata,
  output logic                       o_op_tvalid,
  input  logic                       i_op_tready,
  output logic [2:0]                 o_op_code,
  output logic                       o_op_illegal,
  input  logic                       i_err_clr,
  output logic                       o_err_sticky,
  output logic [$clog2(DEPTH+1)-1:0] o_fill
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH + 1);

  // Returns {code, illegal}; only the dynamic add/sub mode can produce an illegal code.
  function automatic logic [3:0] f_decode(input logic [5:0] d);
    logic [2:0] c;
    logic       ill;
    ill = 1'b0;
    if (OP_SEL == 3) begin
      c = (OP_COMPARE == 0) ? d[5:3] : 3'(OP_COMPARE - 1);
    end else if (OP_PLUS_MINUS == 1) begin
      c = 3'b000;
    end else if (OP_PLUS_MINUS == 2) begin
      c = 3'b001;
    end else begin
      c   = d[2:0];
      ill = (OP_PLUS_MINUS == 0) && (d[2:1] != 2'b00);
    end
    return {c, ill};
  endfunction

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [FW-1:0] r_fill;
  logic          r_tready, r_err;

  logic [3:0]    w_dec, w_head;
  logic          w_acc, w_push, w_pop, w_unused_tdata;
  logic [FW-1:0] w_fill_nxt;

  assign w_unused_tdata = ^i_axi4s_operation_tdata[TDATA_W-1:6];
  assign w_dec  = f_decode(i_axi4s_operation_tdata[5:0]);
  assign w_acc  = i_axi4s_operation_tvalid && r_tready;
  assign w_push = w_acc && !(w_dec[0] && (DROP_ILLEGAL != 0));
  assign w_pop  = (r_fill != '0) && i_op_tready;

  always_comb begin
    w_fill_nxt = r_fill;
    if (w_push && !w_pop)
      w_fill_nxt = r_fill + 1'b1;
    else if (!w_push && w_pop)
      w_fill_nxt = r_fill - 1'b1;
  end

  // tready is registered from next occupancy, so a pop while full only reopens the input a cycle later.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_fill   <= '0;
      r_tready <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_fill   <= w_fill_nxt;
      r_tready <= (w_fill_nxt != FW'(DEPTH));
      if (w_acc && w_dec[0])
        r_err <= 1'b1;
      else if (i_err_clr)
        r_err <= 1'b0;
    end
  end

  always_ff @(posedge i_aclk) begin
    if (w_push) r_mem[r_wptr] <= w_dec;
  end

  assign w_head                   = r_mem[r_rptr];
  assign o_op_tvalid              = (r_fill != '0);
  assign o_op_code                = o_op_tvalid ? w_head[3:1] : 3'b000;
  assign o_op_illegal             = o_op_tvalid && w_head[0];
  assign o_axi4s_operation_tready = r_tready;
  assign o_err_sticky             = r_err;
  assign o_fill                   = r_fill;

endmodule

// File: tb/tb_ipsxe_floating_point_op_channel_v1_1.sv
// Five channel configurations share one stimulus stream; a queue-based model predicts each one.
module tb_ipsxe_floating_point_op_channel_v1_1;

  localparam int NI = 5;
  localparam int D  = 4;
  localparam int OPSEL [NI] = '{0, 0, 3, 3, 0};
  localparam int PM    [NI] = '{0, 0, 0, 0, 2};
  localparam int CMP   [NI] = '{0, 0, 0, 8, 0};
  localparam int DROP  [NI] = '{0, 1, 0, 0, 0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tvalid = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic       op_rdy = 1'b0;
  logic       err_clr = 1'b0;

  logic       d_trdy [NI];
  logic       d_vld  [NI];
  logic [2:0] d_code [NI];
  logic       d_ill  [NI];
  logic       d_err  [NI];
  logic [2:0] d_fill [NI];

  logic [3:0] mq [NI][$];
  logic       m_trdy [NI];
  logic       m_err  [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ipsxe_floating_point_op_channel_v1_1 #(
      .OP_SEL(OPSEL[g]), .OP_PLUS_MINUS(PM[g]), .OP_COMPARE(CMP[g]),
      .TDATA_W(8), .DEPTH(D), .DROP_ILLEGAL(DROP[g])
    ) u_dut (
      .i_aclk(clk), .i_aresetn(rst_n),
      .i_axi4s_operation_tvalid(tvalid), .o_axi4s_operation_tready(d_trdy[g]),
      .i_axi4s_operation_tdata(tdata),
      .o_op_tvalid(d_vld[g]), .i_op_tready(op_rdy),
      .o_op_code(d_code[g]), .o_op_illegal(d_ill[g]),
      .i_err_clr(err_clr), .o_err_sticky(d_err[g]), .o_fill(d_fill[g])
    );
  end

  // {code, illegal} straight from the decode rules
  function automatic logic [3:0] model_dec(int k, logic [7:0] d);
    int code;
    bit ill;
    ill = 0;
    if (OPSEL[k] == 3) code = (CMP[k] == 0) ? int'(d[5:3]) : CMP[k] - 1;
    else if (PM[k] == 1) code = 0;
    else if (PM[k] == 2) code = 1;
    else begin
      code = int'(d[2:0]);
      ill  = (d[2:1] != 0);
    end
    return {3'(code), ill};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) begin
        mq[k].delete();
        m_trdy[k] = 1'b0;
        m_err[k]  = 1'b0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        logic [3:0] e;
        bit acc, pop;
        e   = model_dec(k, tdata);
        acc = tvalid && m_trdy[k];
        pop = (mq[k].size() != 0) && op_rdy;
        if (pop) void'(mq[k].pop_front());
        if (acc && !(e[0] && DROP[k] != 0)) mq[k].push_back(e);
        if (acc && e[0]) m_err[k] = 1'b1;
        else if (err_clr) m_err[k] = 1'b0;
        m_trdy[k] = (mq[k].size() != D);
      end
    end
  end

  task automatic chk(string name, int k, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: actual=%0d required=%0d", name, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      int sz;
      sz = mq[k].size();
      chk("tvalid", k, int'(d_vld[k]), int'(sz != 0));
      chk("code",   k, int'(d_code[k]), (sz != 0) ? int'(mq[k][0][3:1]) : 0);
      chk("illegal", k, int'(d_ill[k]), (sz != 0) ? int'(mq[k][0][0]) : 0);
      chk("fill",   k, int'(d_fill[k]), sz);
      chk("tready", k, int'(d_trdy[k]), int'(m_trdy[k]));
      chk("sticky", k, int'(d_err[k]), int'(m_err[k]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_tready", k, int'(d_trdy[k]), 0);
      chk("rst_fill",   k, int'(d_fill[k]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("tready_after_release", 0, int'(d_trdy[0]), 1);

    // dynamic add/sub codes 0 then 1, core always ready
    tvalid = 1; tdata = 8'h00; op_rdy = 1;
    cyc();
    chk("lit_code0_vld", 0, int'(d_vld[0]), 1);
    chk("lit_code0", 0, int'(d_code[0]), 0);
    tdata = 8'h01;
    cyc();
    chk("lit_code1", 0, int'(d_code[0]), 1);
    chk("lit_code1_ill", 0, int'(d_ill[0]), 0);
    chk("lit_code1_err", 0, int'(d_err[0]), 0);
    tvalid = 0;
    cyc();

    // illegal code 6: queued with flag, or dropped
    tvalid = 1; tdata = 8'h06; op_rdy = 0;
    cyc();
    chk("lit_ill_code", 0, int'(d_code[0]), 6);
    chk("lit_ill_flag", 0, int'(d_ill[0]), 1);
    chk("lit_ill_err",  0, int'(d_err[0]), 1);
    chk("lit_drop_vld", 1, int'(d_vld[1]), 0);
    chk("lit_drop_fill", 1, int'(d_fill[1]), 0);
    chk("lit_drop_err", 1, int'(d_err[1]), 1);
    tvalid = 0; err_clr = 1; op_rdy = 1;
    cyc();
    chk("lit_clr", 0, int'(d_err[0]), 0);
    chk("lit_clr", 1, int'(d_err[1]), 0);
    err_clr = 0;

    // compare decode and static subtract
    tvalid = 1; tdata = 8'h28; op_rdy = 0;
    cyc();
    chk("lit_cmp_dyn", 2, int'(d_code[2]), 5);
    chk("lit_cmp_fix", 3, int'(d_code[3]), 7);
    chk("lit_sub_fix", 4, int'(d_code[4]), 1);
    tvalid = 0; op_rdy = 1;
    repeat (2) cyc();

    // fill to full with backpressure, then one pop
    op_rdy = 0; tvalid = 1;
    for (int i = 0; i < 5; i++) begin
      tdata = 8'(i * 8 + (i & 1));
      cyc();
    end
    chk("lit_full_fill", 0, int'(d_fill[0]), 4);
    chk("lit_full_trdy", 0, int'(d_trdy[0]), 0);
    op_rdy = 1;
    cyc();
    chk("lit_pop_fill", 0, int'(d_fill[0]), 3);
    chk("lit_pop_trdy", 0, int'(d_trdy[0]), 1);
    op_rdy = 0;
    cyc();
    chk("lit_refill", 0, int'(d_fill[0]), 4);
    tvalid = 0; op_rdy = 1;
    repeat (6) cyc();

    // steady push+pop at fill 2
    op_rdy = 0; tvalid = 1;
    repeat (2) begin
      tdata = 8'($urandom) & 8'hF9;
      cyc();
    end
    op_rdy = 1;
    for (int i = 0; i < 10; i++) begin
      tdata = 8'($urandom) & 8'hF9;
      cyc();
      chk("lit_steady_fill", 0, int'(d_fill[0]), 2);
    end
    tvalid = 0;
    repeat (4) cyc();

    // asynchronous reset with three entries queued
    op_rdy = 0; tvalid = 1;
    tdata = 8'h06; cyc();
    tdata = 8'h01; cyc();
    tdata = 8'h00; cyc();
    tvalid = 0;
    chk("lit_pre_rst_fill", 0, int'(d_fill[0]), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_rst_vld",  0, int'(d_vld[0]), 0);
    chk("lit_rst_fill", 0, int'(d_fill[0]), 0);
    chk("lit_rst_err",  0, int'(d_err[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("lit_rel_trdy", 0, int'(d_trdy[0]), 1);
    tvalid = 1; tdata = 8'h01; op_rdy = 1;
    cyc();
    chk("lit_post_rst_code", 0, int'(d_code[0]), 1);
    chk("lit_post_rst_fill", 0, int'(d_fill[0]), 1);
    tvalid = 0;
    cyc();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      tvalid  = ($urandom_range(0, 99) < 65);
      tdata   = 8'($urandom);
      op_rdy  = ($urandom_range(0, 99) < ((i / 200) % 2 == 0 ? 70 : 35));
      err_clr = ($urandom_range(0, 99) < 8);
      cyc();
    end
    tvalid = 0; err_clr = 0; op_rdy = 1;
    repeat (6) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
